mem_port_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory (64 x 32-bit, word-indexed by addr[7:2],

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACC_FETCH = 2'd1,
        ACC_DATA  = 2'd2,
        RESP      = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    localparam int MEM_WORDS_DEFAULT = 64;

    function automatic logic [31:0] byte_limit(input int words);
        return 32'(words * 4);
    endfunction

    localparam logic [31:0] BYTE_ADDR_LIMIT = byte_limit(MEM_WORDS_DEFAULT);

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way requester pick with a last-loser round-robin pointer for conflicts.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    fetch_req,
    input  logic    data_req,
    input  logic    arb_en,
    output logic    any_req,
    output req_id_e winner
);

    logic prefer_data_reg;
    logic prefer_data_next;
    logic conflict;

    assign conflict = fetch_req & data_req;

    always_comb begin
        any_req          = fetch_req | data_req;
        winner           = REQ_FETCH;
        prefer_data_next = prefer_data_reg;
        if (conflict) begin
            winner = ((PRIORITY_MODE == 0) || prefer_data_reg) ? REQ_DATA : REQ_FETCH;
        end else if (data_req) begin
            winner = REQ_DATA;
        end
        // Pointer only moves when a conflict is actually resolved; the loser is preferred next.
        if (arb_en && conflict) begin
            prefer_data_next = (winner == REQ_FETCH);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prefer_data_reg <= 1'b1;
        end else begin
            prefer_data_reg <= prefer_data_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between fetch and load/store,
// one access per three-cycle slot, with a guarded write path.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WORDS     = MEM_WORDS_DEFAULT,
    parameter int PRIORITY_MODE = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetchReq,
    input  logic [31:0] i_fetchAddress,
    output logic        o_fetchGnt,
    output logic        o_fetchValid,
    output logic [31:0] o_instruction,
    input  logic        i_dataReq,
    input  logic        i_dataWriteEnable,
    input  logic [31:0] i_dataAddress,
    input  logic [31:0] i_dataWriteData,
    output logic        o_dataGnt,
    output logic        o_dataValid,
    output logic        o_dataError,
    output logic [31:0] o_readData,
    output logic [31:0] o_memAddress,
    output logic        o_memWriteEnable,
    output logic [31:0] o_memWriteData,
    input  logic [31:0] i_memReadData
);

    localparam logic [31:0] ADDR_LIMIT = byte_limit(MEM_WORDS);

    arb_state_e  state_reg, state_next;
    req_id_e     winner_reg;
    req_id_e     winner;
    logic        any_req;
    logic        accept;
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic        err_reg;
    logic [31:0] instr_reg;
    logic [31:0] rdata_reg;
    logic        data_req_err;
    logic [1:0]  gnt_vec;
    logic [1:0]  resp_vec;

    mem_arb_pick #(
        .PRIORITY_MODE(PRIORITY_MODE)
    ) u_pick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .fetch_req(i_fetchReq),
        .data_req (i_dataReq),
        .arb_en   (state_reg == IDLE),
        .any_req  (any_req),
        .winner   (winner)
    );

    assign accept       = (state_reg == IDLE) && any_req;
    assign data_req_err = (i_dataAddress[1:0] != 2'b00) || (i_dataAddress >= ADDR_LIMIT);

    // Index 0 is the fetch requester, index 1 the load/store requester.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign gnt_vec[gi]  = accept && (winner == ((gi == 0) ? REQ_FETCH : REQ_DATA));
        assign resp_vec[gi] = (state_reg == RESP) &&
                              (winner_reg == ((gi == 0) ? REQ_FETCH : REQ_DATA));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = (winner == REQ_DATA) ? ACC_DATA : ACC_FETCH;
                end
            end
            ACC_FETCH: state_next = RESP;
            ACC_DATA:  state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch: the memory port is driven only from these registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            winner_reg <= REQ_FETCH;
            addr_reg   <= '0;
            we_reg     <= 1'b0;
            wdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else if (accept) begin
            winner_reg <= winner;
            if (winner == REQ_DATA) begin
                addr_reg  <= i_dataAddress;
                we_reg    <= i_dataWriteEnable;
                wdata_reg <= i_dataWriteData;
                err_reg   <= data_req_err;
            end else begin
                addr_reg <= i_fetchAddress;
                we_reg   <= 1'b0;
                err_reg  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instr_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (state_reg == ACC_FETCH) begin
                instr_reg <= i_memReadData;
            end
            if ((state_reg == ACC_DATA) && !we_reg) begin
                rdata_reg <= err_reg ? 32'd0 : i_memReadData;
            end
        end
    end

    assign o_fetchGnt       = gnt_vec[0];
    assign o_dataGnt        = gnt_vec[1];
    assign o_fetchValid     = resp_vec[0];
    assign o_dataValid      = resp_vec[1];
    assign o_dataError      = resp_vec[1] && err_reg;
    assign o_instruction    = instr_reg;
    assign o_readData       = rdata_reg;
    assign o_memAddress     = addr_reg;
    assign o_memWriteData   = wdata_reg;
    assign o_memWriteEnable = (state_reg == ACC_DATA) && we_reg && !err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: fixed-priority instance plus a round-robin instance.
module tb_mem_port_arbiter;

    typedef struct {
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;

    logic        fetch_gnt, fetch_valid, data_gnt, data_valid, data_error, mem_we;
    logic [31:0] instruction, read_data, mem_addr, mem_wdata, mem_rdata;
    logic        fetch_gnt_1, fetch_valid_1, data_gnt_1, data_valid_1, data_error_1, mem_we_1;
    logic [31:0] instruction_1, read_data_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    int   checks;
    int   failures;
    exp_t sb_q[$];
    logic gq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem0[mem_addr[7:2]] <= mem_wdata;
    always @(posedge clk) if (mem_we_1) mem1[mem_addr_1[7:2]] <= mem_wdata_1;
    assign mem_rdata   = mem0[mem_addr[7:2]];
    assign mem_rdata_1 = mem1[mem_addr_1[7:2]];

    mem_port_arbiter #(.MEM_WORDS(64), .PRIORITY_MODE(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fetchReq(fetch_req), .i_fetchAddress(fetch_addr),
        .o_fetchGnt(fetch_gnt), .o_fetchValid(fetch_valid), .o_instruction(instruction),
        .i_dataReq(data_req), .i_dataWriteEnable(data_we), .i_dataAddress(data_addr),
        .i_dataWriteData(data_wdata), .o_dataGnt(data_gnt), .o_dataValid(data_valid),
        .o_dataError(data_error), .o_readData(read_data), .o_memAddress(mem_addr),
        .o_memWriteEnable(mem_we), .o_memWriteData(mem_wdata), .i_memReadData(mem_rdata)
    );

    mem_port_arbiter #(.MEM_WORDS(64), .PRIORITY_MODE(1)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_fetchReq(fetch_req), .i_fetchAddress(fetch_addr),
        .o_fetchGnt(fetch_gnt_1), .o_fetchValid(fetch_valid_1), .o_instruction(instruction_1),
        .i_dataReq(data_req), .i_dataWriteEnable(data_we), .i_dataAddress(data_addr),
        .i_dataWriteData(data_wdata), .o_dataGnt(data_gnt_1), .o_dataValid(data_valid_1),
        .o_dataError(data_error_1), .o_readData(read_data_1), .o_memAddress(mem_addr_1),
        .o_memWriteEnable(mem_we_1), .o_memWriteData(mem_wdata_1), .i_memReadData(mem_rdata_1)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({fetch_gnt, data_gnt, fetch_valid, data_valid, data_error, mem_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000",
                     {fetch_gnt, data_gnt, fetch_valid, data_valid, data_error, mem_we});
        end
        checks++;
        if (instruction !== 32'd0) begin
            failures++; $display("FAIL reset_instr got=%h want=0", instruction);
        end
        checks++;
        if (read_data !== 32'd0) begin
            failures++; $display("FAIL reset_rdata got=%h want=0", read_data);
        end
        checks++;
        if (mem_addr !== 32'd0) begin
            failures++; $display("FAIL reset_maddr got=%h want=0", mem_addr);
        end
        checks++;
        if (mem_wdata !== 32'd0) begin
            failures++; $display("FAIL reset_mwdata got=%h want=0", mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    // One load/store slot on the fixed-priority instance, checked cycle by cycle.
    task automatic run_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        bit   got;
        @(negedge clk);
        data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (data_gnt) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin
            failures++; $display("FAIL data_gnt_timeout addr=%h got=none want=gnt", addr);
            data_req = 1'b0;
            return;
        end
        checks++;
        if (mem_we !== 1'b0) begin
            failures++; $display("FAIL we_in_idle got=%b want=0", mem_we);
        end
        e.chk_rdata = !we; e.rdata = exp_rdata; e.err = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        data_req = 1'b0;
        checks++;
        if (mem_we !== (we & ~exp_err)) begin
            failures++; $display("FAIL we_acc addr=%h got=%b want=%b", addr, mem_we, we & ~exp_err);
        end
        checks++;
        if (mem_addr !== addr) begin
            failures++; $display("FAIL mem_addr got=%h want=%h", mem_addr, addr);
        end
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (data_valid !== 1'b1) begin
            failures++; $display("FAIL data_valid addr=%h got=%b want=1", addr, data_valid);
        end
        checks++;
        if (data_error !== e.err) begin
            failures++; $display("FAIL data_err addr=%h got=%b want=%b", addr, data_error, e.err);
        end
        if (e.chk_rdata) begin
            checks++;
            if (read_data !== e.rdata) begin
                failures++; $display("FAIL load_data addr=%h got=%h want=%h", addr, read_data, e.rdata);
            end
        end
        checks++;
        if (mem_we !== 1'b0) begin
            failures++; $display("FAIL we_in_resp got=%b want=0", mem_we);
        end
        $display("txn data we=%0b addr=%h wdata=%h rdata=%h err=%0b", we, addr, wdata, read_data, data_error);
    endtask

    task automatic test_store_load;
        run_data(1'b1, 32'h10, 32'h1234ABCD, 32'h0, 1'b0);
        run_data(1'b1, 32'h08, 32'h00500093, 32'h0, 1'b0);
        run_data(1'b1, 32'h00, 32'h11111111, 32'h0, 1'b0);
        run_data(1'b1, 32'hFC, 32'h5A5A5A5A, 32'h0, 1'b0);
        run_data(1'b0, 32'h10, 32'h0, 32'h1234ABCD, 1'b0);
        run_data(1'b0, 32'hFC, 32'h0, 32'h5A5A5A5A, 1'b0);
    endtask

    task automatic test_lone_fetch;
        exp_t e;
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'h08;
        #1;
        checks++;
        if (fetch_gnt !== 1'b1) begin
            failures++; $display("FAIL fetch_gnt_n got=%b want=1", fetch_gnt);
        end
        e.chk_rdata = 1'b1; e.rdata = 32'h00500093; e.err = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        checks++;
        if (mem_addr !== 32'h08 || fetch_gnt !== 1'b0 || fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_acc addr=%h gnt=%b valid=%b want 00000008/0/0", mem_addr, fetch_gnt, fetch_valid);
        end
        @(negedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (fetch_valid !== 1'b1 || instruction !== e.rdata) begin
            failures++;
            $display("FAIL fetch_resp valid=%b instr=%h want 1/%h", fetch_valid, instruction, e.rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fetch_valid !== 1'b0) begin
            failures++; $display("FAIL fetch_valid_width got=%b want=0", fetch_valid);
        end
        $display("txn fetch addr=00000008 instr=%h", instruction);
    endtask

    task automatic test_arb_fixed;
        int ndata;
        bit done;
        @(negedge clk);
        gq = {1'b1, 1'b1, 1'b1, 1'b0};
        fetch_req = 1'b1; fetch_addr = 32'h08;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h10;
        ndata = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (fetch_gnt || data_gnt) begin
                checks++;
                if (gq.size() == 0 || (fetch_gnt && data_gnt) || data_gnt !== gq[0]) begin
                    failures++;
                    $display("FAIL fixed_grant fetch=%b data=%b want_data=%b", fetch_gnt, data_gnt,
                             (gq.size() != 0) ? gq[0] : 1'bx);
                end
                if (gq.size() != 0) void'(gq.pop_front());
                $display("txn fixed grant %s", data_gnt ? "data" : "fetch");
                if (data_gnt) ndata++;
                if (fetch_gnt) done = 1'b1;
            end
            @(negedge clk);
            if (ndata >= 3) data_req = 1'b0;
        end
        fetch_req = 1'b0;
        data_req = 1'b0;
        checks++;
        if (!done || gq.size() != 0) begin
            failures++; $display("FAIL fixed_sequence left=%0d done=%0b want 0/1", gq.size(), done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fetch_valid !== 1'b1 || instruction !== 32'h00500093) begin
            failures++; $display("FAIL fixed_fetch valid=%b instr=%h want 1/00500093", fetch_valid, instruction);
        end
        checks++;
        if (read_data !== 32'h1234ABCD) begin
            failures++; $display("FAIL fixed_rdata got=%h want=1234abcd", read_data);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_arb_rr;
        int n;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gq = {1'b1, 1'b0, 1'b1};
        fetch_req = 1'b1; fetch_addr = 32'h08;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h10;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            #1;
            if (fetch_gnt_1 || data_gnt_1) begin
                checks++;
                if ((fetch_gnt_1 && data_gnt_1) || data_gnt_1 !== gq[0]) begin
                    failures++;
                    $display("FAIL rr_grant idx=%0d fetch=%b data=%b want_data=%b", n, fetch_gnt_1, data_gnt_1, gq[0]);
                end
                void'(gq.pop_front());
                $display("txn rr grant %s", data_gnt_1 ? "data" : "fetch");
                n++;
            end
            @(negedge clk);
        end
        fetch_req = 1'b0; data_req = 1'b0;
        checks++;
        if (n != 3) begin
            failures++; $display("FAIL rr_timeout got=%0d want=3", n);
        end
        repeat (4) @(negedge clk);
        fetch_req = 1'b1;
        #1;
        checks++;
        if (fetch_gnt_1 !== 1'b1 || data_gnt_1 !== 1'b0) begin
            failures++; $display("FAIL rr_single fetch=%b data=%b want 1/0", fetch_gnt_1, data_gnt_1);
        end
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (3) @(negedge clk);
        fetch_req = 1'b1; data_req = 1'b1;
        #1;
        checks++;
        if (fetch_gnt_1 !== 1'b1 || data_gnt_1 !== 1'b0) begin
            failures++; $display("FAIL rr_pointer_static fetch=%b data=%b want 1/0", fetch_gnt_1, data_gnt_1);
        end
        $display("txn rr conflict after single fetch -> %s", fetch_gnt_1 ? "fetch" : "data");
        @(negedge clk);
        fetch_req = 1'b0; data_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_error;
        run_data(1'b1, 32'h12,  32'hDEADBEEF, 32'h0, 1'b1);
        run_data(1'b1, 32'h100, 32'hCAFEF00D, 32'h0, 1'b1);
        run_data(1'b0, 32'h10,  32'h0, 32'h1234ABCD, 1'b0);
        run_data(1'b0, 32'h00,  32'h0, 32'h11111111, 1'b0);
        run_data(1'b0, 32'h104, 32'h0, 32'h0, 1'b1);
        run_data(1'b0, 32'h0D,  32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20; data_wdata = 32'h77777777;
        #1;
        checks++;
        if (data_gnt !== 1'b1) begin
            failures++; $display("FAIL midrst_gnt got=%b want=1", data_gnt);
        end
        @(negedge clk);
        data_req = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b1) begin
            failures++; $display("FAIL midrst_we_before got=%b want=1", mem_we);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            failures++; $display("FAIL midrst_we_drop got=%b want=0", mem_we);
        end
        checks++;
        if ({data_valid, data_error, mem_addr, mem_wdata, read_data, instruction} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs valid=%b err=%b maddr=%h mwdata=%h rdata=%h instr=%h want all 0",
                     data_valid, data_error, mem_addr, mem_wdata, read_data, instruction);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (data_valid !== 1'b0 || mem_we !== 1'b0) begin
                failures++; $display("FAIL midrst_no_valid cyc=%0d valid=%b we=%b want 0/0", i, data_valid, mem_we);
            end
            @(negedge clk);
        end
        $display("txn reset during store slot");
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        test_reset();
        test_store_load();
        test_lone_fetch();
        test_arb_fixed();
        test_arb_rr();
        test_error();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
